// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : MEM-stage data memory with programmable wait states and stall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        errAlign,
  output logic        errConflict
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be within 1..15");
    end
  endgenerate

  logic [31:0]       mem [DEPTH];
  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;

  logic w_req;
  logic w_aligned;
  logic w_accept;
  logic w_commit;
  logic w_unused_addr;

  assign w_req         = memRead | memWrite;
  assign w_aligned     = (address[1:0] == 2'b00);
  assign w_accept      = (r_state == S_IDLE) && w_req && w_aligned;
  assign w_commit      = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_unused_addr = ^address[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are silenced while reset is held, even with a request present.
  always_comb begin
    stall       = 1'b0;
    errAlign    = 1'b0;
    errConflict = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          stall       = w_accept;
          errAlign    = w_req && !w_aligned;
          errConflict = memRead && memWrite;
        end
        S_BUSY:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      readData <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_write <= memWrite;
            r_idx   <= address[ADDR_W+1:2];
            r_wdata <= writeData;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else if (!r_write) readData <= mem[r_idx];
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; a reset on the commit edge abandons the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && r_write) mem[r_idx] <= r_wdata;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that services the pipeline's MEM-stage load/store requests. It holds a word-addressed backing array and inserts a programmable number of wait states per access. While an access is outstanding it drives a stall back to the hazard logic, so the pipeline freezes until the data is ready. It replaces the single-cycle data memory and is the responding end of the MEM-stage memRead/memWrite/address/writeData interface.

## Interface

Parameters:
- ADDR_W, 10: word-index width; array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 3: wait states per access. Legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- memRead  in  1  load request from the MEM stage.
- memWrite  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- writeData  in  32  store data.
- readData  out  32  load result, registered.
- stall  out  1  high while an access is outstanding; freezes PC, IF/ID, ID/EXE and EXE/MEM.
- errAlign  out  1  combinational pulse: the request in IDLE has address[1:0] != 0.
- errConflict  out  1  combinational pulse: memRead and memWrite are both high in IDLE.

## Operation

- Word index is address[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- FSM states: IDLE, BUSY, DONE. A 4-bit down-counter cnt tracks wait states.
- IDLE:
  - A valid request is (memRead | memWrite) with address[1:0] == 0.
  - On a valid request: stall = 1, cnt <= WAIT_CYCLES-1, and the FSM goes to BUSY. The op, index and writeData are latched into internal request registers.
  - Misaligned request: errAlign = 1, stall = 0, access dropped, readData unchanged, FSM stays in IDLE.
- BUSY:
  - stall = 1.
  - If cnt != 0, cnt decrements.
  - If cnt == 0, the access commits on this edge and the FSM goes to DONE:
    - a read loads readData from the array;
    - a write stores the latched writeData.
- DONE:
  - stall = 0 and readData is valid; the pipeline advances on this edge.
  - The FSM returns to IDLE unconditionally. The request inputs are not re-sampled in DONE, because they still show the access just completed.
- Simultaneous memRead and memWrite in IDLE: errConflict = 1 and the access is treated as a write. It still stalls normally, and readData is unchanged.
- Request inputs are ignored in BUSY and DONE. Only the latched copy is used.
- Array contents are not initialised or cleared by rst. The bench preloads them hierarchically.

## Timing

- Reset values: state = IDLE, cnt = 0, readData = 0, request registers = 0. While rst is high, stall, errAlign and errConflict are forced to 0.
- stall is combinational in IDLE, so it is high in the same cycle the request appears.
- An access keeps stall high for exactly 1 + WAIT_CYCLES cycles, followed by one DONE cycle with stall = 0.
- Total occupancy is 2 + WAIT_CYCLES cycles.
- Load data is visible on readData in the DONE cycle and is held until the next committed read.
- Back-to-back accesses: the next request is seen in the IDLE cycle right after DONE. The DONE cycle adds no extra stall beyond the one cycle already counted.
- Reset during BUSY: the access is abandoned, a pending write is never committed, and the FSM is in IDLE after the edge.
- Reset during DONE: an already-committed write persists. readData returns to 0.

## Test plan

- Preload word 5 = 0xDEADBEEF; memRead at address 0x14 with WAIT_CYCLES = 3 -> stall high for 4 cycles, then readData = 0xDEADBEEF with stall = 0 in the DONE cycle.
- memWrite of 0x12345678 to 0x40, then memRead of 0x40 in the following IDLE cycle -> two stall windows of 4 cycles each; second result is 0x12345678.
- memRead at 0x7 -> errAlign = 1 for that cycle, stall = 0, readData unchanged, array unchanged.
- memRead and memWrite both high with data 0xA5A5A5A5 to 0x8 -> errConflict = 1, write performed, readData unchanged; a later read of 0x8 returns 0xA5A5A5A5.
- memWrite of 0xFFFFFFFF to 0x20, with rst asserted in the second BUSY cycle -> stall = 0 next cycle, FSM in IDLE; a later read of 0x20 returns the preloaded value.
- With ADDR_W = 10, write 0x11 to 0x1000 -> a read of 0x0 returns 0x11 (wrap-around).
